// File: rtl/step_scheduler.sv
// Turns a signed Q16.FRAC_BITS velocity command into one clamped integer step count per
// fixed window, carrying the fractional remainder forward and tracking commanded position.
module step_scheduler #(
  parameter int WINDOW    = 500_000,
  parameter int FRAC_BITS = 8,
  parameter int MAX_STEPS = 48,
  parameter int PULSE_LEN = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic signed [16+FRAC_BITS-1:0] velocity,
  output logic                        send_steps,
  output logic signed [15:0]          num_steps,
  output logic signed [31:0]          position,
  output logic                        saturated,
  output logic                        window_tick
);

  localparam int VW = 16 + FRAC_BITS;
  localparam int SW = VW + 2;
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int PW = $clog2(PULSE_LEN) + 1;

  localparam logic [CW-1:0]        CNT_LAST   = CW'(WINDOW - 1);
  localparam logic [PW-1:0]        PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic signed [SW-1:0] MAX_POS    = SW'(MAX_STEPS);
  localparam logic signed [SW-1:0] MAX_NEG    = SW'(-MAX_STEPS);
  localparam logic signed [15:0]   CLAMP_POS  = 16'(MAX_STEPS);
  localparam logic signed [15:0]   CLAMP_NEG  = 16'(-MAX_STEPS);

  typedef enum logic [1:0] {IDLE, COUNT, PULSE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_next;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [FRAC_BITS-1:0]  acc_q, acc_d;
  logic signed [15:0]    num_q, num_d;
  logic signed [31:0]    pos_q, pos_d;
  logic                  send_q, send_d;
  logic                  sat_q, sat_d;
  logic                  tick_q, tick_d;
  logic signed [SW-1:0]  sum, n;

  // The carried remainder is an unsigned fraction, so zero-extend it; n is floor(sum).
  always_comb begin
    sum = $signed({{2{velocity[VW-1]}}, velocity}) + $signed({{(SW-FRAC_BITS){1'b0}}, acc_q});
    n   = sum >>> FRAC_BITS;
  end

  assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    acc_d   = acc_q;
    num_d   = num_q;
    pos_d   = pos_q;
    send_d  = send_q;
    sat_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        acc_d  = '0;
        pcnt_d = '0;
        send_d = 1'b0;
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (enable) begin
          cnt_d = cnt_next;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      PULSE: begin
        // The window keeps running under the pulse so the tick period never stretches.
        cnt_d = cnt_next;
        if (pcnt_q == PULSE_LAST) begin
          send_d = 1'b0;
          if (enable) begin
            state_d = COUNT;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tick_q) begin
      if (n > MAX_POS) begin
        num_d = CLAMP_POS;
        acc_d = '0;
        sat_d = 1'b1;
      end else if (n < MAX_NEG) begin
        num_d = CLAMP_NEG;
        acc_d = '0;
        sat_d = 1'b1;
      end else begin
        num_d = n[15:0];
        acc_d = sum[FRAC_BITS-1:0];
      end
      pos_d = pos_q + {{16{num_d[15]}}, num_d};
      // A zero count must not pulse: downstream would emit a step on any send edge.
      if (num_d != '0) begin
        state_d = PULSE;
        send_d  = 1'b1;
        pcnt_d  = '0;
      end
    end

    tick_d = (state_d != IDLE) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      pos_q   <= '0;
      send_q  <= 1'b0;
      sat_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      pos_q   <= pos_d;
      send_q  <= send_d;
      sat_q   <= sat_d;
      tick_q  <= tick_d;
    end
  end

  assign send_steps  = send_q;
  assign num_steps   = num_q;
  assign position    = pos_q;
  assign saturated   = sat_q;
  assign window_tick = tick_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: a cycle-level window/remainder model checked every cycle,
// plus directed windows with hand-computed step counts and positions.
module tb_step_scheduler;

  localparam int WINDOW    = 20;
  localparam int FRAC_BITS = 8;
  localparam int MAX_STEPS = 48;
  localparam int PULSE_LEN = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [23:0] velocity;
  logic        send_steps;
  logic [15:0] num_steps;
  logic [31:0] position;
  logic        saturated;
  logic        window_tick;

  int compared   = 0;
  int mismatched = 0;

  step_scheduler #(
    .WINDOW(WINDOW), .FRAC_BITS(FRAC_BITS), .MAX_STEPS(MAX_STEPS), .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .velocity(velocity),
    .send_steps(send_steps), .num_steps(num_steps), .position(position),
    .saturated(saturated), .window_tick(window_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state: what the outputs must be during the current cycle.
  bit               m_active;
  int               m_phase;
  int               m_pulse_left;
  int               m_acc;
  int               m_num;
  logic signed [31:0] m_pos;
  bit               m_send, m_sat, m_tick;

  task automatic modelReset();
    m_active = 0; m_phase = 0; m_pulse_left = 0; m_acc = 0; m_num = 0;
    m_pos = '0; m_send = 0; m_sat = 0; m_tick = 0;
  endtask

  task automatic modelStep();
    int s, frac, n;
    bit stop, ticking;
    m_sat = 0;
    if (!m_active) begin
      m_send = 0; m_tick = 0; m_acc = 0; m_pulse_left = 0;
      if (enable) begin
        m_active = 1;
        m_phase  = 0;
      end
      return;
    end
    ticking = (m_phase == WINDOW - 1);
    stop = 0;
    if (m_pulse_left > 0) begin
      m_pulse_left--;
      if (m_pulse_left == 0 && !enable) stop = 1;
    end else if (!enable && !ticking) begin
      stop = 1;
    end
    if (ticking) begin
      s    = $signed(velocity) + m_acc;
      frac = s & ((1 << FRAC_BITS) - 1);
      n    = (s - frac) / (1 << FRAC_BITS);
      if (n > MAX_STEPS) begin
        m_num = MAX_STEPS; m_acc = 0; m_sat = 1;
      end else if (n < -MAX_STEPS) begin
        m_num = -MAX_STEPS; m_acc = 0; m_sat = 1;
      end else begin
        m_num = n; m_acc = frac;
      end
      m_pos = m_pos + m_num;
      if (m_num != 0) m_pulse_left = PULSE_LEN;
      else if (!enable) stop = 1;
    end
    if (stop) begin
      m_active = 0; m_phase = 0; m_acc = 0;
    end else begin
      m_phase = (m_phase + 1) % WINDOW;
    end
    m_send = (m_pulse_left > 0);
    m_tick = m_active && (m_phase == WINDOW - 1);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) modelReset();
    else       modelStep();
  end

  always @(negedge clock) begin
    checkOutput("model_tick", 32'(window_tick), 32'(m_tick));
    checkOutput("model_send", 32'(send_steps), 32'(m_send));
    checkOutput("model_sat",  32'(saturated), 32'(m_sat));
    checkOutput("model_num",  32'($signed(num_steps)), m_num);
    checkOutput("model_pos",  position, m_pos);
  end

  task automatic applyStimulus(input bit en, input logic [23:0] vel);
    @(posedge clock);
    #2;
    enable   = en;
    velocity = vel;
  endtask

  // Returns on the negedge of the tick cycle; an expired budget counts as a failure.
  task automatic waitTick(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (window_tick) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL tick_timeout: got no tick, expected one within %0d cycles", budget);
  endtask

  task automatic expectWindow(input string tag, input int exp_num, input int exp_pos,
                              input bit exp_send, input bit exp_sat);
    int c;
    waitTick(60, c);
    @(negedge clock);
    checkOutput({tag, "_num"},  32'($signed(num_steps)), exp_num);
    checkOutput({tag, "_pos"},  position, exp_pos);
    checkOutput({tag, "_send"}, 32'(send_steps), 32'(exp_send));
    checkOutput({tag, "_sat"},  32'(saturated), 32'(exp_sat));
  endtask

  initial begin
    int c, w, ticks;
    reset = 1'b0; enable = 1'b0; velocity = '0;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_num",  32'($signed(num_steps)), 0);
    checkOutput("reset_pos",  position, 0);
    checkOutput("reset_send", 32'(send_steps), 0);
    checkOutput("reset_tick", 32'(window_tick), 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    // 1.5 steps/window alternates 1,2 via the carried half step.
    applyStimulus(1, 24'h000180);
    waitTick(60, c);
    checkOutput("first_tick_delay", c, 21);
    @(negedge clock);
    checkOutput("v15_w1_num", 32'($signed(num_steps)), 1);
    checkOutput("v15_w1_pos", position, 1);
    w = 1;
    repeat (5) begin
      @(negedge clock);
      if (send_steps) w++;
    end
    checkOutput("pulse_width", w, PULSE_LEN);
    waitTick(60, c);
    checkOutput("tick_spacing", c, WINDOW - 6);
    @(negedge clock);
    checkOutput("v15_w2_num", 32'($signed(num_steps)), 2);
    checkOutput("v15_w2_pos", position, 3);
    expectWindow("v15_w3", 1, 4, 1, 0);
    expectWindow("v15_w4", 2, 6, 1, 0);

    applyStimulus(1, 24'hFFFE80);
    expectWindow("vn15_w1", -2, 4, 1, 0);
    expectWindow("vn15_w2", -1, 3, 1, 0);
    expectWindow("vn15_w3", -2, 1, 1, 0);
    expectWindow("vn15_w4", -1, 0, 1, 0);

    repeat (6) @(negedge clock);
    applyStimulus(0, 24'h000040);
    repeat (3) @(posedge clock);
    applyStimulus(1, 24'h000040);
    expectWindow("v025_w1", 0, 0, 0, 0);
    expectWindow("v025_w2", 0, 0, 0, 0);
    expectWindow("v025_w3", 0, 0, 0, 0);
    expectWindow("v025_w4", 1, 1, 1, 0);

    applyStimulus(1, 24'h006400);
    expectWindow("sat_pos_w1", 48, 49, 1, 1);
    @(negedge clock);
    checkOutput("sat_one_cycle", 32'(saturated), 0);
    expectWindow("sat_pos_w2", 48, 97, 1, 1);
    applyStimulus(1, 24'hFF9C00);
    expectWindow("sat_neg_w1", -48, 49, 1, 1);
    expectWindow("sat_neg_w2", -48, 1, 1, 1);

    // Leave a half step in the accumulator, then drop enable mid-window.
    applyStimulus(1, 24'h000180);
    expectWindow("pre_drop", 1, 2, 1, 0);
    repeat (8) @(negedge clock);
    applyStimulus(0, 24'h000080);
    ticks = 0;
    repeat (50) begin
      @(negedge clock);
      if (window_tick) ticks++;
    end
    checkOutput("no_tick_disabled", ticks, 0);
    applyStimulus(1, 24'h000080);
    expectWindow("reen_w1", 0, 2, 0, 0);
    expectWindow("reen_w2", 1, 3, 1, 0);

    // Reset in the second cycle of a pulse.
    applyStimulus(1, 24'h000180);
    expectWindow("pre_reset", 1, 4, 1, 0);
    @(posedge clock);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    checkOutput("midpulse_send", 32'(send_steps), 0);
    checkOutput("midpulse_num",  32'($signed(num_steps)), 0);
    checkOutput("midpulse_pos",  position, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    ticks = 0;
    repeat (30) begin
      @(negedge clock);
      if (window_tick) ticks++;
    end
    checkOutput("no_tick_after_reset", ticks, 0);
    applyStimulus(1, 24'h000180);
    waitTick(60, c);
    checkOutput("post_reset_delay", c, 21);
    @(negedge clock);
    checkOutput("post_reset_num", 32'($signed(num_steps)), 1);
    checkOutput("post_reset_pos", position, 1);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
